ifetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of main_control in the single-cycle processor.
- Holds the PC and fetches a 32-bit word from instruction memory with a req/ready handshake.
- Presents the word to decode (Opcode = instr[31:26], Imm16 = instr[15:0]).
- Computes the next PC from main_control's nPC_sel, and halts on a HALT opcode.

---
 rtl/ifetch_unit_if.sv | 22 ++
 rtl/ifetch_unit.sv | 114 +++++++++++
 tb/tb_ifetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read channel between the fetch stage (master) and instruction memory (slave).
// The request is held together with a stable address until the memory answers with ready.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over a req/ready
// channel, presents it to decode and advances the PC sequentially or to a branch target.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                nPC_sel,
    input  logic                stall,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc_next_s;
    logic        req_s;
    logic        valid_s;
    logic        halted_s;
    logic        is_halt_s;

    // Word-aligned, sign-extended branch displacement from the 16-bit immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    assign pc_plus4  = pc_r + 32'd4;
    assign is_halt_s = (instr_r[31:26] == HALT_OPCODE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stall outranks both HALT and branch decisions
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = REQ;
            REQ: begin
                if (imem.imem_ready) state_s = EXEC;
                else                 state_s = REQ;
            end
            EXEC: begin
                if (stall)          state_s = EXEC;
                else if (is_halt_s) state_s = HALT;
                else                state_s = REQ;
            end
            HALT:    state_s = HALT;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the state register, so reset clears them immediately
    always_comb begin
        req_s    = 1'b0;
        valid_s  = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            REQ:     req_s    = 1'b1;
            EXEC:    valid_s  = 1'b1;
            HALT:    halted_s = 1'b1;
            default: req_s    = 1'b0;
        endcase
    end

    // Next PC selection; arithmetic wraps modulo 2^32
    always_comb begin
        pc_next_s = pc_plus4;
        if (nPC_sel) pc_next_s = pc_plus4 + branch_offset(instr_r[15:0]);
        else         pc_next_s = pc_plus4;
    end

    // PC and instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
        end else begin
            if (state_r == REQ && imem.imem_ready) begin
                instr_r <= imem.imem_rdata;
            end
            if (state_r == EXEC && !stall && !is_halt_s) begin
                pc_r <= pc_next_s;
            end
        end
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign instr_valid    = valid_s;
    assign pc             = pc_r;
    assign halted         = halted_s;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic checked
// against an instruction-level reference model of the fetch/execute rules.
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] RTYPE    = 32'h0022_1820;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nPC_sel = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;

    ifetch_unit_if imem ();

    ifetch_unit #(.RESET_PC(RESET_PC), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .rst_n(rst_n), .nPC_sel(nPC_sel), .stall(stall), .imem(imem),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 = idle cycle, 1 = fetching, 2 = executing, 3 = halted
    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    task automatic do_reset();
        rst_n = 1'b0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        nPC_sel = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_st = 0;
        m_pc = RESET_PC;
        m_instr = 32'h0;
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, then clock.
    task automatic step(input logic rdy, input logic [31:0] word, input logic npc, input logic stl);
        imem.imem_ready = rdy;
        imem.imem_rdata = word;
        nPC_sel = npc;
        stall = stl;
        case (m_st)
            0: m_st = 1;
            1: if (rdy) begin m_instr = word; m_st = 2; end
            2: if (!stl) begin
                if (m_instr[31:26] == 6'b111111) m_st = 3;
                else begin
                    m_pc = m_pc + 32'd4 + (npc ? 32'(int'($signed(m_instr[15:0])) * 4) : 32'd0);
                    m_st = 1;
                end
            end
            default: m_st = m_st;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++; if (pc !== RESET_PC) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h expected 0", instr); end
        tests++; if ({imem.imem_req, instr_valid, halted} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {imem.imem_req, instr_valid, halted}); end
        do_reset();
        tests++; if (imem.imem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %b expected 0", imem.imem_req); end
        step(1'b1, RTYPE, 1'b0, 1'b0);
        tests++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin fails++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem.imem_req, imem.imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        int k = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tests++; if (imem.imem_req !== (m_st == 1) || instr_valid !== (m_st == 2)) begin fails++; $display("FAIL seq_phase: got req=%b valid=%b at cycle %0d", imem.imem_req, instr_valid, c); end
            if (m_st == 1) begin
                tests++; if (imem.imem_addr !== 32'(k * 4)) begin fails++; $display("FAIL seq_addr: got %h expected %h", imem.imem_addr, 32'(k * 4)); end
                k++;
            end
            if (m_st == 2) begin
                tests++; if (pc_plus4 !== pc + 32'd4) begin fails++; $display("FAIL seq_pc_plus4: got %h expected %h", pc_plus4, pc + 32'd4); end
            end
            step(1'b1, RTYPE, 1'b0, 1'b0);
        end
        tests++; if (k !== 3) begin fails++; $display("FAIL seq_count: got %0d requests expected 3", k); end
    endtask

    task automatic test_branch();
        do_reset();
        step(1'b1, RTYPE, 1'b0, 1'b0);
        step(1'b1, 32'h1000_0003, 1'b0, 1'b0);
        tests++; if (instr !== 32'h1000_0003) begin fails++; $display("FAIL br_instr: got %h expected 10000003", instr); end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h10) begin fails++; $display("FAIL br_fwd: got %h expected 00000010", pc); end
        step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h0C) begin fails++; $display("FAIL br_back: got %h expected 0000000c", pc); end
        step(1'b1, 32'h1000_0003, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h1C) begin fails++; $display("FAIL br_fwd2: got %h expected 0000001c", pc); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        step(1'b1, RTYPE, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, $urandom, 1'b1, 1'b0);
            tests++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC || instr_valid !== 1'b0) begin fails++; $display("FAIL wait_hold: got req=%b addr=%h valid=%b", imem.imem_req, imem.imem_addr, instr_valid); end
        end
        step(1'b1, 32'h0123_4567, 1'b0, 1'b0);
        tests++; if (instr !== 32'h0123_4567 || instr_valid !== 1'b1) begin fails++; $display("FAIL wait_load: got %h valid=%b expected 01234567 valid=1", instr, instr_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b1, RTYPE, 1'b0, 1'b0);
        step(1'b1, 32'h1000_0005, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step(1'b1, $urandom, 1'b1, 1'b1);
            tests++; if (pc !== 32'h0 || instr !== 32'h1000_0005 || instr_valid !== 1'b1) begin fails++; $display("FAIL stall_hold: got pc=%h instr=%h valid=%b", pc, instr, instr_valid); end
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h18 || imem.imem_req !== 1'b1) begin fails++; $display("FAIL stall_release: got pc=%h req=%b expected pc=00000018 req=1", pc, imem.imem_req); end
    endtask

    task automatic test_halt();
        do_reset();
        step(1'b1, RTYPE, 1'b0, 1'b0);
        step(1'b1, 32'hFC00_0000, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b1, 1'b0);
        tests++; if (halted !== 1'b1 || pc !== 32'h0 || instr_valid !== 1'b0) begin fails++; $display("FAIL halt_enter: got halted=%b pc=%h valid=%b", halted, pc, instr_valid); end
        for (int c = 0; c < 12; c++) begin
            step(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            tests++; if (imem.imem_req !== 1'b0 || halted !== 1'b1 || pc !== 32'h0 || instr !== 32'hFC00_0000) begin fails++; $display("FAIL halt_frozen: got req=%b halted=%b pc=%h instr=%h", imem.imem_req, halted, pc, instr); end
        end
        rst_n = 1'b0;
        #1;
        tests++; if (halted !== 1'b0 || pc !== RESET_PC) begin fails++; $display("FAIL halt_reset: got halted=%b pc=%h", halted, pc); end
        do_reset();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        step(1'b1, RTYPE, 1'b0, 1'b0);
        step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        tests++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_target: got pc=%h pc_plus4=%h", pc, pc_plus4); end
        step(1'b1, RTYPE, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_seq: got %h expected 00000000", pc); end
        step(1'b1, RTYPE, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        tests++; if (imem.imem_req !== 1'b1 || pc !== 32'h4) begin fails++; $display("FAIL pre_reset: got req=%b pc=%h", imem.imem_req, pc); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (imem.imem_req !== 1'b0 || pc !== RESET_PC) begin fails++; $display("FAIL async_reset: got req=%b pc=%h", imem.imem_req, pc); end
        do_reset();
        tests++; if (imem.imem_req !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got req=%b expected 0", imem.imem_req); end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        tests++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin fails++; $display("FAIL post_reset_req: got req=%b addr=%h", imem.imem_req, imem.imem_addr); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tests++; if (imem.imem_req !== (m_st == 1) || instr_valid !== (m_st == 2) || halted !== (m_st == 3)) begin fails++; $display("FAIL rnd_phase: got req=%b valid=%b halted=%b model phase %0d", imem.imem_req, instr_valid, halted, m_st); end
            tests++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin fails++; $display("FAIL rnd_pc: got pc=%h pc_plus4=%h expected pc=%h", pc, pc_plus4, m_pc); end
            if (m_st == 1) begin
                tests++; if (imem.imem_addr !== m_pc) begin fails++; $display("FAIL rnd_addr: got %h expected %h", imem.imem_addr, m_pc); end
            end
            if (m_st == 2) begin
                tests++; if (instr !== m_instr) begin fails++; $display("FAIL rnd_instr: got %h expected %h", instr, m_instr); end
            end
            if (m_st == 3 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                w = $urandom;
                if (w[31:26] == 6'b111111) w[31:26] = 6'b000100;
                if ($urandom_range(0, 39) == 0) w[31:26] = 6'b111111;
                step(($urandom_range(0, 9) < 7), w, 1'($urandom), ($urandom_range(0, 3) == 0));
            end
        end
    endtask

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        m_st = 0;
        m_pc = RESET_PC;
        m_instr = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_mem_wait();
        test_stall();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
